// File: rtl/reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and constants for the reset sequencer: the sequencing FSM
// state encoding and the reset-cause codes reported on cause_o.
// ---------------------------------------------------------------------------
package reset_seq_pkg;

   // Sequencer phases: hold everything, release channels one by one, run.
   typedef enum logic [1:0] {
      ASSERT  = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2
   } state_t;

   localparam int CAUSE_W = 2;

   localparam logic [CAUSE_W-1:0] CAUSE_POR = 2'b00;
   localparam logic [CAUSE_W-1:0] CAUSE_EXT = 2'b01;
   localparam logic [CAUSE_W-1:0] CAUSE_SW  = 2'b10;

endpackage

// File: rtl/reset_glitch_filter.sv
// ---------------------------------------------------------------------------
// reset_glitch_filter
// Synchronises the asynchronous active-low external reset pin with two flops
// and counts consecutive synchronised low samples. trig is high while that
// run has reached FILTER_CYCLES; the first synchronised high sample clears it.
//
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset (sync flops -> 1, count -> 0)
//   pin_n  : asynchronous external reset pin, active-low
//   trig   : filtered external reset request, active-high
// ---------------------------------------------------------------------------
module reset_glitch_filter #(
   parameter int FILTER_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pin_n,
   output logic trig
);

   localparam int FW = $clog2(FILTER_CYCLES + 1);
   localparam logic [FW-1:0] RUN_MAX = FW'(FILTER_CYCLES);

   logic          sync1_r;
   logic          sync2_r;
   logic [FW-1:0] run_cnt_r;

   // Two-flop synchroniser and saturating low-run counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r   <= 1'b1;
         sync2_r   <= 1'b1;
         run_cnt_r <= '0;
      end else begin
         sync1_r <= pin_n;
         sync2_r <= sync1_r;
         if (sync2_r) begin
            run_cnt_r <= '0;
         end else if (run_cnt_r != RUN_MAX) begin
            run_cnt_r <= run_cnt_r + 1'b1;
         end else begin
            run_cnt_r <= run_cnt_r;
         end
      end
   end

   // Decoded straight from the counter register, so it is glitch-free.
   assign trig = (run_cnt_r == RUN_MAX);

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Holds all downstream resets for POR_CYCLES after the last reset request,
// raises porb_o, then releases CHANNELS reset domains in ascending order,
// STAGE_GAP cycles apart, each optionally held off by chan_hold_i. Any
// request (wb_rst_i, filtered external pin, sw_rst_i) restarts the sequence.
//
// Ports:
//   wb_clk_i     : sole clock
//   wb_rst_i     : synchronous active-high reset, also a POR-cause request
//   ext_rst_n_i  : asynchronous external reset pin, active-low
//   sw_rst_i     : single-cycle synchronous software reset request
//   chan_hold_i  : per-channel release hold-off
//   porb_o       : power-good, high once the POR interval has elapsed
//   por_o        : inverse of porb_o
//   rst_o        : per-domain active-high resets
//   busy_o       : high while any rst_o bit is high
//   cause_o      : cause of last reset (00 POR, 01 EXT, 10 SW)
// ---------------------------------------------------------------------------
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int CNT_W         = 16,
   parameter int POR_CYCLES    = 500,
   parameter int STAGE_GAP     = 16,
   parameter int FILTER_CYCLES = 4
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                ext_rst_n_i,
   input  logic                sw_rst_i,
   input  logic [CHANNELS-1:0] chan_hold_i,
   output logic                porb_o,
   output logic                por_o,
   output logic [CHANNELS-1:0] rst_o,
   output logic                busy_o,
   output logic [CAUSE_W-1:0]  cause_o
);

   localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

   localparam bit PARAMS_OK = (CHANNELS >= 1) && (POR_CYCLES >= 1) &&
                              (STAGE_GAP >= 1) && (FILTER_CYCLES >= 1) &&
                              (CNT_W >= 1) && (CNT_W < 63) &&
                              (longint'(POR_CYCLES - 1) < CNT_SPAN) &&
                              (longint'(STAGE_GAP - 1) < CNT_SPAN);

   generate
      if (!PARAMS_OK) begin : g_param_check
         $fatal(1, "reset_sequencer: illegal parameter combination");
      end
   endgenerate

   localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

   logic ext_trig;
   logic req;

   state_t               state_r,  state_s;
   logic [CNT_W-1:0]     cnt_r,    cnt_s;
   logic [CNT_W-1:0]     gap_r,    gap_s;
   logic [IDX_W-1:0]     idx_r,    idx_s;
   logic [CHANNELS-1:0]  rst_r,    rst_s;
   logic                 porb_r,   porb_s;
   logic                 busy_r,   busy_s;
   logic [CAUSE_W-1:0]   cause_r,  cause_s;

   reset_glitch_filter #(
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .pin_n (ext_rst_n_i),
      .trig  (ext_trig)
   );

   assign req = wb_rst_i | ext_trig | sw_rst_i;

   // Next-state, counters, channel resets and cause decode.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      gap_s   = gap_r;
      idx_s   = idx_r;
      rst_s   = rst_r;
      porb_s  = porb_r;
      cause_s = cause_r;

      if (req) begin
         state_s = ASSERT;
         cnt_s   = '0;
         gap_s   = '0;
         idx_s   = '0;
         rst_s   = '1;
         porb_s  = 1'b0;
         if (wb_rst_i) begin
            cause_s = CAUSE_POR;
         end else if (ext_trig) begin
            cause_s = CAUSE_EXT;
         end else begin
            cause_s = CAUSE_SW;
         end
      end else begin
         case (state_r)
            ASSERT: begin
               rst_s  = '1;
               porb_s = 1'b0;
               if (cnt_r == POR_LAST) begin
                  state_s = RELEASE;
                  idx_s   = '0;
                  gap_s   = '0;
                  porb_s  = 1'b1;
               end else begin
                  cnt_s = cnt_r + 1'b1;
               end
            end
            RELEASE: begin
               // A held channel parks gap at its last value, so the release
               // fires on the first edge that sees the hold low.
               if (gap_r == GAP_LAST) begin
                  if (!chan_hold_i[idx_r]) begin
                     rst_s[idx_r] = 1'b0;
                     gap_s        = '0;
                     if (idx_r == IDX_LAST) begin
                        state_s = RUN;
                        idx_s   = '0;
                     end else begin
                        idx_s = idx_r + 1'b1;
                     end
                  end else begin
                     gap_s = gap_r;
                  end
               end else begin
                  gap_s = gap_r + 1'b1;
               end
            end
            RUN: begin
               rst_s  = '0;
               porb_s = 1'b1;
            end
            default: begin
               state_s = ASSERT;
               cnt_s   = '0;
               gap_s   = '0;
               idx_s   = '0;
               rst_s   = '1;
               porb_s  = 1'b0;
            end
         endcase
      end

      busy_s = |rst_s;
   end

   // State and output registers.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r <= ASSERT;
         cnt_r   <= '0;
         gap_r   <= '0;
         idx_r   <= '0;
         rst_r   <= '1;
         porb_r  <= 1'b0;
         busy_r  <= 1'b1;
         cause_r <= CAUSE_POR;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         gap_r   <= gap_s;
         idx_r   <= idx_s;
         rst_r   <= rst_s;
         porb_r  <= porb_s;
         busy_r  <= busy_s;
         cause_r <= cause_s;
      end
   end

   assign porb_o  = porb_r;
   assign por_o   = ~porb_r;
   assign rst_o   = rst_r;
   assign busy_o  = busy_r;
   assign cause_o = cause_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
// Directed bench for reset_sequencer: default-parameter instance plus a
// minimal instance (1 channel, 1-cycle POR and gap).
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       wb_rst = 1'b1;
   logic       ext_n = 1'b1;
   logic       sw = 1'b0;
   logic [3:0] hold = 4'h0;
   logic       porb, por, busy;
   logic [3:0] rst;
   logic [1:0] cause;

   logic       wb_rst2 = 1'b1;
   logic       ext_n2 = 1'b1;
   logic       sw2 = 1'b0;
   logic [0:0] hold2 = 1'b0;
   logic       porb2, por2, busy2;
   logic [0:0] rst2;
   logic [1:0] cause2;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   reset_sequencer dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (wb_rst),
      .ext_rst_n_i (ext_n),
      .sw_rst_i    (sw),
      .chan_hold_i (hold),
      .porb_o      (porb),
      .por_o       (por),
      .rst_o       (rst),
      .busy_o      (busy),
      .cause_o     (cause)
   );

   reset_sequencer #(
      .CHANNELS      (1),
      .CNT_W         (4),
      .POR_CYCLES    (1),
      .STAGE_GAP     (1),
      .FILTER_CYCLES (1)
   ) dut_small (
      .wb_clk_i    (clk),
      .wb_rst_i    (wb_rst2),
      .ext_rst_n_i (ext_n2),
      .sw_rst_i    (sw2),
      .chan_hold_i (hold2),
      .porb_o      (porb2),
      .por_o       (por2),
      .rst_o       (rst2),
      .busy_o      (busy2),
      .cause_o     (cause2)
   );

   // Advance one edge; outputs are then stable and inputs may be driven.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      tick(3);
      compared++;
      if (rst !== 4'hF || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_rst got rst=%h busy=%b want rst=f busy=1", rst, busy);
      end
      compared++;
      if (porb !== 1'b0 || por !== 1'b1 || cause !== 2'b00) begin
         mismatched++;
         $display("FAIL reset_por got porb=%b por=%b cause=%b want 0 1 00", porb, por, cause);
      end
      wb_rst = 1'b0;   // the third edge above is E0
   endtask

   task automatic test_por_sequence;
      tick(499);
      compared++;
      if (porb !== 1'b0 || rst !== 4'hF) begin
         mismatched++;
         $display("FAIL por_e0p499 got porb=%b rst=%h want 0 f", porb, rst);
      end
      tick(1);
      compared++;
      if (porb !== 1'b1 || por !== 1'b0 || rst !== 4'hF) begin
         mismatched++;
         $display("FAIL por_e0p500 got porb=%b por=%b rst=%h want 1 0 f", porb, por, rst);
      end
      tick(15);
      compared++;
      if (rst !== 4'hF) begin
         mismatched++;
         $display("FAIL ch0_early got %h want f", rst);
      end
      tick(1);
      compared++;
      if (rst !== 4'hE) begin
         mismatched++;
         $display("FAIL ch0_e0p516 got %h want e", rst);
      end
      tick(15);
      compared++;
      if (rst !== 4'hE) begin
         mismatched++;
         $display("FAIL ch1_early got %h want e", rst);
      end
      tick(1);
      compared++;
      if (rst !== 4'hC) begin
         mismatched++;
         $display("FAIL ch1_e0p532 got %h want c", rst);
      end
      tick(16);
      compared++;
      if (rst !== 4'h8 || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL ch2_e0p548 got rst=%h busy=%b want 8 1", rst, busy);
      end
      tick(15);
      compared++;
      if (rst !== 4'h8 || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL ch3_early got rst=%h busy=%b want 8 1", rst, busy);
      end
      tick(1);
      compared++;
      if (rst !== 4'h0 || busy !== 1'b0 || cause !== 2'b00) begin
         mismatched++;
         $display("FAIL ch3_e0p564 got rst=%h busy=%b cause=%b want 0 0 00", rst, busy, cause);
      end
   endtask

   task automatic test_ext_filter;
      // Short pulse: only 3 synchronised low samples.
      ext_n = 1'b0;
      tick(3);
      ext_n = 1'b1;
      tick(10);
      compared++;
      if (rst !== 4'h0 || porb !== 1'b1 || cause !== 2'b00) begin
         mismatched++;
         $display("FAIL ext_short got rst=%h porb=%b cause=%b want 0 1 00", rst, porb, cause);
      end
      // Long pulse: trig after edge 6, outputs after edge 7, last req edge 13.
      ext_n = 1'b0;
      tick(6);
      compared++;
      if (rst !== 4'h0 || porb !== 1'b1) begin
         mismatched++;
         $display("FAIL ext_latency got rst=%h porb=%b want 0 1", rst, porb);
      end
      tick(1);
      compared++;
      if (rst !== 4'hF || porb !== 1'b0 || busy !== 1'b1 || cause !== 2'b01) begin
         mismatched++;
         $display("FAIL ext_trigger got rst=%h porb=%b busy=%b cause=%b want f 0 1 01", rst, porb, busy, cause);
      end
      tick(3);
      ext_n = 1'b1;
      tick(3);
      tick(499);
      compared++;
      if (porb !== 1'b0) begin
         mismatched++;
         $display("FAIL ext_por_early got %b want 0", porb);
      end
      tick(1);
      compared++;
      if (porb !== 1'b1 || cause !== 2'b01) begin
         mismatched++;
         $display("FAIL ext_por_rise got porb=%b cause=%b want 1 01", porb, cause);
      end
      tick(64);
      compared++;
      if (rst !== 4'h0 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL ext_run got rst=%h busy=%b want 0 0", rst, busy);
      end
   endtask

   task automatic test_sw_cause;
      sw = 1'b1;
      wb_rst = 1'b1;
      tick(1);
      sw = 1'b0;
      wb_rst = 1'b0;
      compared++;
      if (cause !== 2'b00 || rst !== 4'hF || porb !== 1'b0) begin
         mismatched++;
         $display("FAIL sw_with_wb got cause=%b rst=%h porb=%b want 00 f 0", cause, rst, porb);
      end
      tick(564);
      compared++;
      if (rst !== 4'h0 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL sw_wb_run got rst=%h busy=%b want 0 0", rst, busy);
      end
      sw = 1'b1;
      tick(1);
      sw = 1'b0;
      compared++;
      if (cause !== 2'b10 || rst !== 4'hF || porb !== 1'b0 || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL sw_alone got cause=%b rst=%h porb=%b busy=%b want 10 f 0 1", cause, rst, porb, busy);
      end
   endtask

   // Starts right after the software request edge of test_sw_cause.
   task automatic test_hold;
      hold = 4'b0010;
      tick(500);
      compared++;
      if (porb !== 1'b1 || rst !== 4'hF) begin
         mismatched++;
         $display("FAIL hold_por got porb=%b rst=%h want 1 f", porb, rst);
      end
      tick(16);
      compared++;
      if (rst !== 4'hE) begin
         mismatched++;
         $display("FAIL hold_ch0 got %h want e", rst);
      end
      tick(84);
      compared++;
      if (rst !== 4'hE || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL hold_blocked got rst=%h busy=%b want e 1", rst, busy);
      end
      hold = 4'b0000;
      tick(1);
      compared++;
      if (rst !== 4'hC) begin
         mismatched++;
         $display("FAIL hold_drop got %h want c", rst);
      end
      tick(15);
      compared++;
      if (rst !== 4'hC) begin
         mismatched++;
         $display("FAIL hold_ch2_early got %h want c", rst);
      end
      tick(1);
      compared++;
      if (rst !== 4'h8) begin
         mismatched++;
         $display("FAIL hold_ch2 got %h want 8", rst);
      end
   endtask

   task automatic test_mid_sw;
      sw = 1'b1;
      tick(1);
      sw = 1'b0;
      tick(532);
      compared++;
      if (rst !== 4'hC) begin
         mismatched++;
         $display("FAIL mid_ch1 got %h want c", rst);
      end
      sw = 1'b1;
      tick(1);
      sw = 1'b0;
      compared++;
      if (rst !== 4'hF || busy !== 1'b1 || porb !== 1'b0 || cause !== 2'b10) begin
         mismatched++;
         $display("FAIL mid_restart got rst=%h busy=%b porb=%b cause=%b want f 1 0 10", rst, busy, porb, cause);
      end
      tick(499);
      compared++;
      if (porb !== 1'b0) begin
         mismatched++;
         $display("FAIL mid_por_early got %b want 0", porb);
      end
      tick(1);
      compared++;
      if (porb !== 1'b1) begin
         mismatched++;
         $display("FAIL mid_por_rise got %b want 1", porb);
      end
      tick(64);
      hold = 4'hF;
      tick(5);
      compared++;
      if (rst !== 4'h0 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL run_hold_ignored got rst=%h busy=%b want 0 0", rst, busy);
      end
      hold = 4'h0;
   endtask

   task automatic test_small_params;
      wb_rst2 = 1'b1;
      tick(1);
      wb_rst2 = 1'b0;
      compared++;
      if (porb2 !== 1'b0 || rst2 !== 1'b1 || busy2 !== 1'b1) begin
         mismatched++;
         $display("FAIL small_e0 got porb=%b rst=%b busy=%b want 0 1 1", porb2, rst2, busy2);
      end
      tick(1);
      compared++;
      if (porb2 !== 1'b1 || rst2 !== 1'b1) begin
         mismatched++;
         $display("FAIL small_e0p1 got porb=%b rst=%b want 1 1", porb2, rst2);
      end
      tick(1);
      compared++;
      if (rst2 !== 1'b0 || busy2 !== 1'b0 || cause2 !== 2'b00) begin
         mismatched++;
         $display("FAIL small_e0p2 got rst=%b busy=%b cause=%b want 0 0 00", rst2, busy2, cause2);
      end
   endtask

   initial begin
      test_reset;
      test_por_sequence;
      test_ext_filter;
      test_sw_cause;
      test_hold;
      test_mid_sw;
      test_small_params;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
